// File: rtl/slt_iterative_cmp.sv
// slt_iterative_cmp: multi-cycle set-less-than comparator.
// Walks the operands CHUNK bits per cycle from the MSB chunk downwards and
// stops at the first chunk that differs. Signed mode is handled by flipping
// the sign bit at capture, so every chunk compare is a plain unsigned one.
module slt_iterative_cmp #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             eq
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [IDXW-1:0]   idx;
  logic              done_q, lt_q, eq_q;

  logic [CHUNK-1:0]  a_chunk, b_chunk;
  logic              chunk_lt, chunk_ne, last_chunk, decide;
  logic [WIDTH-1:0]  msb_flip;

  // Chunk selection and per-chunk decision
  always_comb begin
    a_chunk    = a_q[idx*CHUNK +: CHUNK];
    b_chunk    = b_q[idx*CHUNK +: CHUNK];
    chunk_lt   = (a_chunk < b_chunk);
    chunk_ne   = (a_chunk != b_chunk);
    last_chunk = (idx == '0);
    decide     = chunk_ne || last_chunk;
    msb_flip   = is_signed ? (WIDTH'(1) << (WIDTH-1)) : '0;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start)  state_nx = RUN;
      RUN:  if (decide) state_nx = IDLE;
      default:          state_nx = IDLE;
    endcase
  end

  // Operand capture, chunk walk and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      done_q <= 1'b0;
      lt_q   <= 1'b0;
      eq_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          // offset-binary: sign bit inverted so unsigned chunk compares order signed values
          a_q <= a ^ msb_flip;
          b_q <= b ^ msb_flip;
          idx <= IDXW'(NCHUNK - 1);
        end
      end else if (decide) begin
        done_q <= 1'b1;
        lt_q   <= chunk_lt;
        eq_q   <= ~chunk_ne;
      end else begin
        idx <= idx - 1'b1;
      end
    end
  end

  // Output decode
  always_comb begin
    busy   = (state == RUN);
    done   = done_q;
    result = WIDTH'(lt_q);
    eq     = eq_q;
  end

endmodule

// File: tb/tb_slt_iterative_cmp.sv
// Self-checking bench for slt_iterative_cmp (WIDTH=64, CHUNK=16).
// Expected outcomes are queued when a start is driven and checked when done
// pulses; latency is checked as the cycle distance from start to done.
module tb_slt_iterative_cmp;

  localparam int unsigned W = 64;
  localparam int unsigned C = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         is_signed = 1'b0;
  logic         busy, done, eq;
  logic [W-1:0] result;

  slt_iterative_cmp #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .is_signed(is_signed), .busy(busy), .done(done),
    .result(result), .eq(eq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lt;
    logic        eq;
    int unsigned k;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         lt;
    logic         eq;
    int unsigned  k;
  } vec_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {63'd0, done}, '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, W'(e.lt));
        chk("eq", {63'd0, eq}, W'(e.eq));
        chk("latency", W'(cyc - e.cyc), W'(e.k + 1));
        chk("busy_at_done", {63'd0, busy}, '0);
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic s);
    exp_t e;
    logic found;
    e.lt  = s ? ($signed(va) < $signed(vb)) : (va < vb);
    e.eq  = (va == vb);
    e.k   = W / C;
    e.cyc = 0;
    found = 1'b0;
    for (int i = W/C - 1; i >= 0; i--) begin
      if (!found && va[i*C +: C] != vb[i*C +: C]) begin
        e.k   = W/C - i;
        found = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input vec_t v);
    exp_t e;
    a = v.a; b = v.b; is_signed = v.s; start = 1'b1;
    e.lt = v.lt; e.eq = v.eq; e.k = v.k; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      chk("done_timeout", W'(sb.size()), '0);
      sb.delete();
    end
  endtask

  task automatic run(input vec_t v);
    drive_start(v);
    step();
    start = 1'b0;
    wait_empty();
    step();
  endtask

  vec_t vecs[12];
  vec_t v, v2;
  exp_t m;

  initial begin
    vecs[0]  = '{64'h1, 64'h2, 1'b0, 1'b1, 1'b0, 4};
    vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1, 1'b0, 1};
    vecs[3]  = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1};
    vecs[4]  = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b1, 4};
    vecs[6]  = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 1'b1, 4};
    vecs[7]  = '{64'h0, 64'h1, 1'b0, 1'b1, 1'b0, 4};
    vecs[8]  = '{64'h3, 64'h5, 1'b1, 1'b1, 1'b0, 4};
    vecs[9]  = '{64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 2};
    vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 4};
    vecs[11] = '{64'h0000_0000_8000_0000, 64'h0000_0000_7FFF_FFFF, 1'b1, 1'b0, 1'b0, 3};

    // reset state
    step();
    step();
    chk("rst_busy",   {63'd0, busy}, '0);
    chk("rst_done",   {63'd0, done}, '0);
    chk("rst_result", result, '0);
    chk("rst_eq",     {63'd0, eq}, '0);
    rst = 1'b0;
    step();

    // directed table
    for (int i = 0; i < 12; i++) run(vecs[i]);

    // random operands differing in one random chunk, checked against a behavioural model
    for (int i = 0; i < 8; i++) begin
      v.a = {$urandom, $urandom};
      v.b = v.a;
      if (i != 7) v.b[$urandom_range(0, 3)*C +: C] = 16'($urandom);
      v.s = 1'($urandom);
      m = model(v.a, v.b, v.s);
      v.lt = m.lt; v.eq = m.eq; v.k = m.k;
      run(v);
    end

    // start while busy is ignored; operand inputs change during RUN
    v = '{64'h1, 64'h2, 1'b0, 1'b1, 1'b0, 4};
    drive_start(v);
    step();
    start = 1'b0;
    a = 64'h5; b = 64'h0;
    step();
    start = 1'b1; is_signed = 1'b1;
    chk("busy_mid_run", {63'd0, busy}, 64'h1);
    step();
    start = 1'b0;
    a = '1; b = '0;
    wait_empty();
    repeat (4) step();

    // back-to-back: second start accepted in the done cycle
    v  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b0, 1'b0, 1};
    v2 = '{64'h3, 64'h5, 1'b0, 1'b1, 1'b0, 4};
    drive_start(v);
    step();
    start = 1'b0;
    step();
    drive_start(v2);
    step();
    start = 1'b0;
    wait_empty();
    step();

    // reset mid-run: outputs drop asynchronously, no done follows
    v = '{64'h1, 64'h2, 1'b0, 1'b1, 1'b0, 4};
    drive_start(v);
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("arst_busy",   {63'd0, busy}, '0);
    chk("arst_done",   {63'd0, done}, '0);
    chk("arst_result", result, '0);
    chk("arst_eq",     {63'd0, eq}, '0);
    sb.delete();
    step();
    step();
    rst = 1'b0;
    repeat (6) step();
    chk("post_rst_idle", {63'd0, busy}, '0);
    run('{64'h3, 64'h5, 1'b0, 1'b1, 1'b0, 4});

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slt_iterative_cmp.md
Name: slt_iterative_cmp

Overview:
- Multi-cycle, parametrised set-less-than unit. Successor to the single-cycle 64-bit SLT/SLTU comparators.
- Compares two WIDTH-bit operands CHUNK bits per cycle, starting at the MSB chunk, and terminates early on the first unequal chunk.
- Supports signed and unsigned mode per operation through a mode input. Result is SLT-style: bit 0 holds the flag, all other bits are 0.
- Sits beside the ALU as a low-area comparator for the execute stage. The issue logic talks to it through a start/busy/done handshake.

Parameters:
- WIDTH, 64, operand and result width. Must be a multiple of CHUNK.
- CHUNK, 16, bits compared per cycle. Must be ≥1 and divide WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a compare. Sampled only while busy=0.
- a  input  WIDTH  left operand, captured when start is accepted
- b  input  WIDTH  right operand, captured when start is accepted
- is_signed  input  1  1 = two's-complement compare (SLT), 0 = unsigned compare (SLTU). Captured with the operands.
- busy  output  1  high while a compare is in progress
- done  output  1  one-cycle pulse when result/eq are updated
- result  output  WIDTH  bit 0 = (a < b); bits WIDTH-1:1 are always 0
- eq  output  1  operands were equal. Valid from done until the next done.

Behaviour:
- Reset: rst asynchronous, active-high. Forces state=IDLE, busy=0, done=0, result=0, eq=0, chunk index=0, operand registers=0.
- States:
  - IDLE:
    - busy=0.
    - If start=1: latch a, b and is_signed; set idx=NCHUNK-1; go to RUN.
  - RUN:
    - busy=1. Each cycle compares chunk idx, bits [idx*CHUNK+CHUNK-1 : idx*CHUNK], of the latched operands.
    - Sign handling: when is_signed=1, bit WIDTH-1 of both latched operands is inverted at capture (offset-binary). After that every chunk compare is unsigned. No subtracter and no overflow correction are needed.
    - a_chunk < b_chunk: result[0]=1, eq=0, done=1, go to IDLE.
    - a_chunk > b_chunk: result[0]=0, eq=0, done=1, go to IDLE.
    - Equal and idx=0: result[0]=0, eq=1, done=1, go to IDLE.
    - Equal and idx>0: idx decrements, stay in RUN.
- done: high for exactly one cycle, the cycle after the deciding chunk. In that cycle state is IDLE and busy=0.
- Latency: start high in cycle 0 (while IDLE) → done high in cycle k+1, where k = number of chunks examined (1..NCHUNK).
  - Worst case NCHUNK+1 cycles. Best case 2 cycles.
- result and eq hold their values until the next done. They are not cleared when a new start is accepted.
- Back-to-back: start is accepted in the done cycle, because the block is in IDLE there.
- start while busy=1 is ignored. Operands are not re-latched and the current compare is unaffected.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- Reset mid-RUN aborts the compare:
  - No done pulse.
  - Outputs return to reset values immediately (asynchronously).
  - The first rising edge after rst deasserts sees IDLE.
- CHUNK=WIDTH is legal: single-cycle compare, done always in cycle 2.

Test Plan (WIDTH=64, CHUNK=16):
- Unsigned near-equal: a=1, b=2, is_signed=0, start in cycle 0 → busy cycles 1–4, done in cycle 5, result=64'h1, eq=0.
- Early termination: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, is_signed=0 → done in cycle 2, result=0. Same operands with is_signed=1 (−1 < 0) → done in cycle 2, result=64'h1.
- Signed extremes: a=64'h8000_0000_0000_0000, b=64'h7FFF_FFFF_FFFF_FFFF, is_signed=1 → result=1, done cycle 2. Same operands with is_signed=0 → result=0.
- Equality: a=b=64'h1234_5678_9ABC_DEF0, either mode → done in cycle 5, result=0, eq=1. Then a new compare with a=0, b=1 → eq returns to 0 at its done.
- Handshake:
  - Assert start again in cycle 2 of a 4-chunk run with different operands → ignored; the original result is reported.
  - Assert start in the done cycle → accepted; its done arrives k+1 cycles later.
  - Change a/b inputs during RUN → result unaffected.
- Reset mid-operation: assert rst in cycle 3 of a 4-chunk run → busy, done, result, eq drop to 0 without waiting for clk, and no done pulse follows. After rst deasserts, a fresh start with a=3, b=5 gives result=1 in cycle 5.
